ifu_fetch: RTL

- Instruction fetch stage, directly upstream of the decode stage.
- Holds the architectural PC and fetches one 32-bit instruction per transaction from a 64-bit instruction memory port.
- Presents {instruction, pc} to decode through a valid/ready handshake.
- Takes the decoder's combinational jump/branch redirect and uses it to form the next PC.

---
 rtl/ifu_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage sitting directly upstream of decode.
//
// Holds the architectural PC and fetches one 32-bit instruction per
// transaction from a 64-bit instruction memory port. It allows one
// outstanding memory request at a time. The fetched {inst, inst_pc} pair is
// presented to decode through a valid/ready handshake. The PC that follows a
// handshake comes from decode's combinational redirect when that is asserted,
// and is pc+4 otherwise.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   imem_req        - fetch request valid (high only in S_REQ)
//   imem_addr       - doubleword-aligned fetch address {pc[XLEN-1:3], 3'b0}
//   imem_gnt        - memory accepts the request this cycle
//   imem_rvalid     - memory read data valid
//   imem_rdata      - 64-bit read doubleword
//   inst_valid      - instruction/pc valid toward decode (high only in S_VALID)
//   inst_ready      - decode accepts this cycle
//   inst            - fetched 32-bit instruction
//   inst_pc         - PC of inst
//   redirect_valid  - decode's jump/branch taken for the presented instruction
//   redirect_addr   - decode's jump/branch target
//   fetch_cnt       - number of instructions handed to decode (wraps)
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [63:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic [63:0]     fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     word_sel;
    logic            capture;
    logic            handshake;

    // Memory is always addressed by doubleword; the word inside it is
    // picked with pc[2] when the response arrives.
    assign imem_addr = {pc[XLEN-1:3], 3'b000};
    assign word_sel  = pc[2] ? imem_rdata[63:32] : imem_rdata[31:0];

    // The redirect is only meaningful on the handshake cycle. pc+4 wraps
    // naturally at the top of the address space.
    assign pc_next = redirect_valid ? redirect_addr : pc + XLEN'(4);

    // Next-state and output decode. imem_req and inst_valid depend on the
    // state alone, so decode and memory never see a combinational loop
    // through this stage. A same-cycle grant plus rvalid in S_REQ is a
    // zero-latency memory and is captured directly. rvalid arriving in any
    // other situation is a stray and is ignored.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        capture    = 1'b1;
                        state_next = S_VALID;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    handshake  = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // State, PC and output registers. Reset wins over everything, including
    // a transaction that is in flight. Once inst and inst_pc are captured,
    // they stay frozen until decode takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            inst      <= 32'd0;
            inst_pc   <= '0;
            fetch_cnt <= 64'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                inst    <= word_sel;
                inst_pc <= pc;
            end
            if (handshake) begin
                pc        <= pc_next;
                fetch_cnt <= fetch_cnt + 64'd1;
            end
        end
    end

endmodule
